// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard and stall controller: load-use bubbles, multi-cycle FP freeze,
// mispredict flush and data-cache miss freeze, plus a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned FP_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_src_fp,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRd,
    input  logic             ex_RegWr,
    input  logic             ex_RegWr_fp,
    input  logic             ex_fp_multi,
    input  logic             ex_mispredict,
    input  logic             dcache_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic             fp_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {StRun, StFpBusy, StMemWait} state_e;

    localparam logic [3:0] LatInit = 4'(FP_LAT - 2);

    state_e           state_q, state_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic             resume_fp_q, resume_fp_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic rs_match, int_hit, fp_hit, load_use;

    assign rs_match = (id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd));
    // x0 is hardwired in the integer file, but f0 is a real FP register
    assign int_hit  = ex_RegWr && !id_src_fp && (ex_rd != 5'd0);
    assign fp_hit   = ex_RegWr_fp && id_src_fp;
    assign load_use = ex_MemRd && rs_match && (int_hit || fp_hit);

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        resume_fp_d = resume_fp_q;
        if (dcache_stall) begin
            // Remember whether an FP op was in flight so its count survives the miss
            if (state_q != StMemWait) begin
                resume_fp_d = (state_q == StFpBusy);
            end
            state_d = StMemWait;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (ex_fp_multi) begin
                        state_d   = StFpBusy;
                        lat_cnt_d = LatInit;
                    end
                end
                StFpBusy: begin
                    if (lat_cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 4'd1;
                    end
                end
                StMemWait: begin
                    state_d     = resume_fp_q ? StFpBusy : StRun;
                    resume_fp_d = 1'b0;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        fp_busy    = 1'b0;
        if (!rst) begin
            fp_busy = (state_q == StFpBusy);
            if (dcache_stall || (state_q == StMemWait) || (state_q == StFpBusy)) begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
                ex_hold = 1'b1;
            end else if (ex_mispredict) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            lat_cnt_q      <= 4'd0;
            resume_fp_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            resume_fp_q    <= resume_fp_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: table of single-cycle vectors plus
// hand-written FP freeze, cache-miss, reset and counter-saturation sequences.
module tb_hazard_stall_ctrl;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       sfp;
        logic [4:0] rd;
        logic       mrd;
        logic       rw;
        logic       rwf;
        logic       fpm;
        logic       mis;
        logic       dc;
        logic [6:0] exp;
        int         cnt;
    } vec_t;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, ex_hold, fp_busy}
    localparam logic [6:0] NORM = 7'b1101000;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] MIS  = 7'b1111100;
    localparam logic [6:0] FRZ  = 7'b0000010;
    localparam logic [6:0] FPB  = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst, rst_sat;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_src_fp;
    logic        ex_MemRd, ex_RegWr, ex_RegWr_fp, ex_fp_multi, ex_mispredict, dcache_stall;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, ex_hold, fp_busy;
    logic [31:0] stall_cycles;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_ex_hold, s_fp_busy;
    logic [1:0]  s_stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.FP_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_src_fp(id_src_fp), .ex_rd(ex_rd), .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr),
        .ex_RegWr_fp(ex_RegWr_fp), .ex_fp_multi(ex_fp_multi), .ex_mispredict(ex_mispredict),
        .dcache_stall(dcache_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .ex_hold(ex_hold), .fp_busy(fp_busy),
        .stall_cycles(stall_cycles)
    );

    // Narrow counter sharing the stimulus, reset only once, to observe saturation
    hazard_stall_ctrl #(.FP_LAT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst_sat),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_src_fp(id_src_fp), .ex_rd(ex_rd), .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr),
        .ex_RegWr_fp(ex_RegWr_fp), .ex_fp_multi(ex_fp_multi), .ex_mispredict(ex_mispredict),
        .dcache_stall(dcache_stall),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_flush(s_idex_flush), .ex_hold(s_ex_hold), .fp_busy(s_fp_busy),
        .stall_cycles(s_stall_cycles)
    );

    function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic sfp,
                                input logic [4:0] rd, input logic mrd, input logic rw,
                                input logic rwf, input logic fpm, input logic mis, input logic dc,
                                input logic [6:0] exp, input int cnt);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.sfp = sfp;
        v.rd = rd; v.mrd = mrd; v.rw = rw; v.rwf = rwf; v.fpm = fpm; v.mis = mis; v.dc = dc;
        v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_src_fp = v.sfp; ex_rd = v.rd; ex_MemRd = v.mrd; ex_RegWr = v.rw;
        ex_RegWr_fp = v.rwf; ex_fp_multi = v.fpm; ex_mispredict = v.mis; dcache_stall = v.dc;
    endtask

    task automatic check(input string name, input logic [6:0] exp, input int cnt);
        logic [6:0] act;
        act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, ex_hold, fp_busy};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: outputs=%b required=%b", name, act, exp);
        end
        n_vec++;
        if (stall_cycles !== 32'(cnt)) begin
            n_err++;
            $display("FAIL %s: stall_cycles=%0d required=%0d", name, stall_cycles, cnt);
        end
    endtask

    // Drive at posedge+1, compare before the following negedge, then advance one cycle
    task automatic step(input vec_t v);
        drive(v);
        #3;
        check(v.name, v.exp, v.cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic check_sat(input string name);
        n_vec++;
        if (s_stall_cycles !== 2'b11) begin
            n_err++;
            $display("FAIL %s: stall_cycles=%0d required=3", name, s_stall_cycles);
        end
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
        tbl[1]  = mk("int_lu_rs1",      5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, LU,   0);
        tbl[2]  = mk("lu_one_cycle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1);
        tbl[3]  = mk("int_lu_x0",       0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, NORM, 1);
        tbl[4]  = mk("int_lu_rs2",      0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, LU,   1);
        tbl[5]  = mk("rs2_unused",      0, 7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, NORM, 2);
        tbl[6]  = mk("alu_no_load",     5, 0, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, NORM, 2);
        tbl[7]  = mk("fp_lu_rs2",       0, 3, 0, 1, 1, 3, 1, 0, 1, 0, 0, 0, LU,   2);
        tbl[8]  = mk("fp_ld_int_src",   0, 3, 0, 1, 0, 3, 1, 0, 1, 0, 0, 0, NORM, 3);
        tbl[9]  = mk("fp_lu_f0",        0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, LU,   3);
        tbl[10] = mk("int_ld_fp_src",   5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, NORM, 4);
        tbl[11] = mk("mis_over_lu",     5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0, MIS,  4);
        tbl[12] = mk("mis_alone",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MIS,  4);
        tbl[13] = mk("rd_mismatch",     6, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, NORM, 4);

        rst = 1'b1;
        rst_sat = 1'b1;
        drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0));
        @(posedge clk);
        #1;
        check("reset_forced_out", NORM, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_sat = 1'b0;

        foreach (tbl[i]) step(tbl[i]);
        check_sat("sat_after_4_stalls");

        // FP op: 3 frozen cycles, mispredict pulses ignored
        step(mk("fp_enter",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NORM, 4));
        step(mk("fp_busy1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FPB,  4));
        step(mk("fp_busy2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FPB,  5));
        step(mk("fp_busy3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FPB,  6));
        step(mk("fp_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 7));
        check_sat("sat_held");

        // Cache miss lands in FP_BUSY with lat_cnt=1 for 5 cycles, then FP resumes
        step(mk("fpm_enter",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NORM, 7));
        step(mk("fpm_busy",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FPB,  7));
        step(mk("fpm_miss1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FPB,  8));
        for (int k = 2; k <= 5; k++) begin
            step(mk($sformatf("fpm_miss%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 7 + k));
        end
        step(mk("fpm_miss_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ,  13));
        step(mk("fpm_resume1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FPB,  14));
        step(mk("fpm_resume2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FPB,  15));
        step(mk("fpm_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 16));

        // Cache miss from RUN beats mispredict and load-use
        step(mk("dc_over_all",   5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 1, FRZ,  16));
        step(mk("dc_exit",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ,  17));
        step(mk("dc_run",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 18));

        // Reset aborts FP_BUSY and MEM_WAIT
        step(mk("rfp_enter",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NORM, 18));
        step(mk("rfp_busy",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FPB,  18));
        rst = 1'b1;
        step(mk("rfp_rst",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 19));
        rst = 1'b0;
        step(mk("rfp_after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0));
        step(mk("rmw_miss",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,  0));
        rst = 1'b1;
        step(mk("rmw_rst",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 1));
        rst = 1'b0;
        step(mk("rmw_after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0));
        check_sat("sat_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
